// File: rtl/hc595_pkg.sv
// hc595_pkg: shared types and width helpers for the 74HC595 frame driver.
// Holds the FSM state encoding and the counter width helper.
package hc595_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    // Counter width for a range of n values; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hc595_pwm.sv
// hc595_pwm: free-running brightness counter with on-time compare.
// Ports: clk, rst (sync, high), brightness (on-time), pwm_on (counter < brightness).
module hc595_pwm #(
    parameter int PWM_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] brightness,
    output logic             pwm_on
);

    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // brightness=0 never compares true, so the chain stays dark.
    assign pwm_on = (cnt_q < brightness);

endmodule

// File: rtl/hc595_frame_driver.sv
// hc595_frame_driver: shifts one DATA_W-bit frame into a 74HC595 chain, then
// pulses stcp. Ports: clk, rst (sync, high), data_in/load/ready handshake,
// ds/shcp/stcp/oe pins. Optional macro HC595_OE_PWM_EN adds the brightness
// input and PWM-gated oe.
module hc595_frame_driver
    import hc595_pkg::*;
#(
    parameter int DATA_W    = 14,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 0,
    parameter int PWM_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
`ifdef HC595_OE_PWM_EN
    input  logic [PWM_W-1:0]  brightness,
`endif
    output logic              ds,
    output logic              shcp,
    output logic              stcp,
    output logic              oe
);

    if (DATA_W < 1 || DIV < 2 || (DIV % 2) != 0 || PWM_W < 1) begin : g_bad_param
        $error("hc595_frame_driver: illegal DATA_W/DIV/PWM_W");
    end

    localparam int PH_W  = cnt_w(DIV);
    localparam int BIT_W = cnt_w(DATA_W);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_e            state_q,   state_d;
    logic [PH_W-1:0]   phase_q,   phase_d;
    logic [BIT_W-1:0]  bit_q,     bit_d;
    logic [DATA_W-1:0] sreg_q,    sreg_d;
    logic              ds_q,      ds_d;
    logic              shcp_q,    shcp_d;
    logic              stcp_q,    stcp_d;
    logic              ready_q,   ready_d;
    logic              oe_q,      oe_d;
    logic              latched_q, latched_d;

    logic              accept;
    logic              gate_on;

`ifdef HC595_OE_PWM_EN
    hc595_pwm #(
        .PWM_W(PWM_W)
    ) u_pwm (
        .clk       (clk),
        .rst       (rst),
        .brightness(brightness),
        .pwm_on    (gate_on)
    );
`else
    assign gate_on = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        sreg_d    = sreg_q;
        ds_d      = 1'b0;
        latched_d = latched_q;
        accept    = 1'b0;

        unique case (state_q)
            IDLE: begin
                accept = load;
            end
            SHIFT: begin
                phase_d = phase_q + 1'b1;
                ds_d    = ds_q;
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = LATCH;
                        bit_d   = '0;
                        ds_d    = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        if (MSB_FIRST != 0) begin
                            ds_d   = sreg_q[DATA_W-1];
                            sreg_d = sreg_q << 1;
                        end else begin
                            ds_d   = sreg_q[0];
                            sreg_d = sreg_q >> 1;
                        end
                    end
                end
            end
            LATCH: begin
                phase_d = phase_q + 1'b1;
                if (phase_q == PH_LAST) begin
                    phase_d   = '0;
                    state_d   = IDLE;
                    latched_d = 1'b1;
                    // The last latch cycle also accepts, so a held load
                    // streams frames with no idle cycle between them.
                    accept    = load;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The first bit goes straight to ds; sreg keeps only what remains.
        if (accept) begin
            state_d = SHIFT;
            phase_d = '0;
            bit_d   = '0;
            if (MSB_FIRST != 0) begin
                ds_d   = data_in[DATA_W-1];
                sreg_d = data_in << 1;
            end else begin
                ds_d   = data_in[0];
                sreg_d = data_in >> 1;
            end
        end

        // Pin values are decoded from the next state so each pin is a flop.
        shcp_d  = (state_d == SHIFT) && (phase_d >= PH_HALF);
        stcp_d  = (state_d == LATCH) && (phase_d >= PH_HALF);
        ready_d = (state_d == IDLE);
        oe_d    = ~(latched_d & gate_on);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            sreg_q    <= '0;
            ds_q      <= 1'b0;
            shcp_q    <= 1'b0;
            stcp_q    <= 1'b0;
            ready_q   <= 1'b1;
            oe_q      <= 1'b1;
            latched_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            sreg_q    <= sreg_d;
            ds_q      <= ds_d;
            shcp_q    <= shcp_d;
            stcp_q    <= stcp_d;
            ready_q   <= ready_d;
            oe_q      <= oe_d;
            latched_q <= latched_d;
        end
    end

    assign ds    = ds_q;
    assign shcp  = shcp_q;
    assign stcp  = stcp_q;
    assign ready = ready_q;
    assign oe    = oe_q;

endmodule

// File: tb/tb_hc595_frame_driver.sv
// tb_hc595_frame_driver: scoreboard bench for two driver instances
// (LSB-first and MSB-first) sharing the same stimulus.
module tb_hc595_frame_driver;

    localparam int DW  = 14;
    localparam int DV  = 4;
    localparam int FP  = (DW + 1) * DV;
    localparam int INF = 32'h7fff_ffff;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          load    = 1'b1;
    logic [DW-1:0] data_in = '0;

    logic [1:0] rd_w, ds_w, sh_w, st_w, oe_w;

    hc595_frame_driver #(
        .DATA_W(DW), .DIV(DV), .MSB_FIRST(0), .PWM_W(4)
    ) u_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load),
        .ready(rd_w[0]), .ds(ds_w[0]), .shcp(sh_w[0]),
        .stcp(st_w[0]), .oe(oe_w[0])
    );

    hc595_frame_driver #(
        .DATA_W(DW), .DIV(DV), .MSB_FIRST(1), .PWM_W(4)
    ) u_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load),
        .ready(rd_w[1]), .ds(ds_w[1]), .shcp(sh_w[1]),
        .stcp(st_w[1]), .oe(oe_w[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            s;
    } frame_t;

    frame_t q[$];
    int cyc        = 0;
    int frame_end  = 0;
    int first_done = INF;
    int total      = 0;
    int bad        = 0;

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d: got %0h want %0h",
                     nm, k, cyc, act, exp);
        end
    endtask

    // Reference model: a frame occupies FP cycles from its accept; a new
    // request is taken when idle or in the final cycle of the previous frame.
    int     mp;
    frame_t mf;
    always @(posedge clk) begin
        mp = cyc;
        if (rst) begin
            q.delete();
            frame_end  = mp + 1;
            first_done = INF;
        end else if (load && (mp + 1 >= frame_end)) begin
            mf.data = data_in;
            mf.s    = mp + 1;
            q.push_back(mf);
            frame_end = mp + 1 + FP;
            if (first_done == INF) first_done = mp + 1 + FP;
        end
        cyc = mp + 1;
    end

    // Monitor: expected pin levels per cycle from the frame at queue head,
    // plus the word reassembled from ds at every shcp rise.
    logic [1:0]    prv_sh = '0;
    logic [DW-1:0] cap [2];
    int            ncap [2];
    logic [DW-1:0] expw;
    logic          e_ds, e_sh, e_st, e_rd, e_oe;
    int            r, j;
    bit            done;

    initial begin
        cap[0] = '0; cap[1] = '0; ncap[0] = 0; ncap[1] = 0;
    end

    always @(negedge clk) begin
        done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e_rd = (cyc >= frame_end);
            e_oe = !(first_done != INF && cyc >= first_done);
            e_ds = 1'b0; e_sh = 1'b0; e_st = 1'b0;
            if (q.size() > 0 && cyc >= q[0].s) begin
                r = cyc - q[0].s;
                if (r < DW * DV) begin
                    j    = r / DV;
                    e_ds = (k == 0) ? q[0].data[j] : q[0].data[DW-1-j];
                    e_sh = ((r % DV) >= DV / 2);
                end else begin
                    e_st = ((r % DV) >= DV / 2);
                end
                if (r == FP - 1) done = 1'b1;
            end
            chk("ready", k, 32'(rd_w[k]), 32'(e_rd));
            chk("ds",    k, 32'(ds_w[k]), 32'(e_ds));
            chk("shcp",  k, 32'(sh_w[k]), 32'(e_sh));
            chk("stcp",  k, 32'(st_w[k]), 32'(e_st));
            chk("oe",    k, 32'(oe_w[k]), 32'(e_oe));
            if (sh_w[k] === 1'b1 && prv_sh[k] == 1'b0) begin
                if (ncap[k] < DW) cap[k][ncap[k]] = ds_w[k];
                ncap[k]++;
            end
            prv_sh[k] = (sh_w[k] === 1'b1);
            if (done) begin
                for (int b = 0; b < DW; b++)
                    expw[b] = (k == 0) ? q[0].data[b] : q[0].data[DW-1-b];
                chk("nbits", k, 32'(ncap[k]), 32'(DW));
                chk("word",  k, 32'(cap[k]),  32'(expw));
                ncap[k] = 0;
                cap[k]  = '0;
            end
            if (rst) begin
                ncap[k] = 0;
                cap[k]  = '0;
            end
        end
        if (done) void'(q.pop_front());
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            data_in = DW'($urandom);
            step(1);
        end
    endtask

    int n;

    initial begin
        data_in = DW'($urandom);
        step(3);
        rst  = 1'b0;
        load = 1'b0;
        idle(4);

        data_in = 14'h2A5B;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
        idle(70);

        data_in = 14'h2A5B;
        load    = 1'b1;
        step(11);
        data_in = 14'h0001;
        step(50);
        load    = 1'b0;
        idle(70);

        data_in = 14'h2A5B;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
        idle(20);
        rst     = 1'b1;
        step(1);
        rst     = 1'b0;
        idle(20);
        load    = 1'b1;
        step(1);
        load    = 1'b0;
        idle(70);

        for (int it = 0; it < 30; it++) begin
            data_in = DW'($urandom);
            load    = 1'b1;
            step($urandom_range(1, 3));
            load    = 1'b0;
            n = $urandom_range(0, 75);
            for (int c = 0; c < n; c++) begin
                data_in = DW'($urandom);
                load    = ($urandom_range(0, 9) == 0);
                rst     = ($urandom_range(0, 199) == 0);
                step(1);
            end
            rst  = 1'b0;
            load = 1'b0;
        end
        idle(2 * FP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
